wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 137 +++++++++++++
 tb/tb_wb_arbiter2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant between a CPU (m0) and a DMA
// (m1) onto one intercon master port, with a wait-state timeout and abort.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [31:0] m0_ADDR,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK,
    output logic        m0_ERR,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [31:0] m1_ADDR,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK,
    output logic        m1_ERR,
    output logic        s_STB,
    output logic        s_WE,
    output logic [31:0] s_ADDR,
    output logic [31:0] s_DAT_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK,
    output logic [1:0]  gnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             sel, sel_nxt;            // granted master: 0 = m0, 1 = m1
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             busy;
    logic             gstb;
    logic             tmo;

    // State, grant select, round-robin pointer and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Next-state logic and datapath steering from the granted master
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        s_STB          = 1'b0;
        s_WE           = 1'b0;
        s_ADDR         = '0;
        s_DAT_O        = '0;
        m0_DAT_O       = '0;
        m1_DAT_O       = '0;
        m0_ACK         = 1'b0;
        m1_ACK         = 1'b0;
        m0_ERR         = 1'b0;
        m1_ERR         = 1'b0;
        gnt            = 2'b00;

        busy = (state == BUSY);
        gstb = sel ? m1_STB : m0_STB;
        tmo  = (cnt == CNT_W'(TIMEOUT - 1));

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (m0_STB && m1_STB) begin
                    sel_nxt   = ~last_grant;
                    state_nxt = BUSY;
                end else if (m0_STB || m1_STB) begin
                    sel_nxt   = m1_STB;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // ACK beats both abort and timeout
                if (s_ACK) begin
                    last_grant_nxt = sel;
                    state_nxt      = RELEASE;
                end else if (!gstb) begin
                    last_grant_nxt = sel;
                    state_nxt      = IDLE;
                end else if (tmo) begin
                    last_grant_nxt = sel;
                    state_nxt      = RELEASE;
                end else if (cnt != CNT_W'(TIMEOUT)) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (busy) begin
            gnt     = sel ? 2'b10 : 2'b01;
            s_STB   = gstb;
            s_WE    = sel ? m1_WE    : m0_WE;
            s_ADDR  = sel ? m1_ADDR  : m0_ADDR;
            s_DAT_O = sel ? m1_DAT_I : m0_DAT_I;
            if (sel) begin
                m1_DAT_O = s_DAT_I;
                m1_ACK   = s_ACK;
                m1_ERR   = gstb && !s_ACK && tmo;
            end else begin
                m0_DAT_O = s_DAT_I;
                m0_ACK   = s_ACK;
                m0_ERR   = gstb && !s_ACK && tmo;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_wb_arbiter2;

    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_STB, m0_WE, m1_STB, m1_WE;
    logic [31:0] m0_ADDR, m0_DAT_I, m0_DAT_O, m1_ADDR, m1_DAT_I, m1_DAT_O;
    logic        m0_ACK, m0_ERR, m1_ACK, m1_ERR;
    logic        s_STB, s_WE, s_ACK;
    logic [31:0] s_ADDR, s_DAT_O, s_DAT_I;
    logic [1:0]  gnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADDR(m0_ADDR), .m0_DAT_I(m0_DAT_I),
        .m0_DAT_O(m0_DAT_O), .m0_ACK(m0_ACK), .m0_ERR(m0_ERR),
        .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADDR(m1_ADDR), .m1_DAT_I(m1_DAT_I),
        .m1_DAT_O(m1_DAT_O), .m1_ACK(m1_ACK), .m1_ERR(m1_ERR),
        .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
        .s_DAT_I(s_DAT_I), .s_ACK(s_ACK), .gnt(gnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // phase: 0 = waiting for a request, 1 = transfer in progress, 2 = handover gap
    int          mp_phase = 0;
    int          mp_owner = 0;
    int          mp_last  = 1;
    int          mp_n     = 0;   // 1-based count of transfer cycles so far
    logic        e_sstb, e_swe, o_stb;
    logic [31:0] e_saddr, e_sdat;
    logic [1:0]  e_gnt;
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_dat [2];

    // Compare all outputs against the model, then advance the model by one edge
    always @(negedge clk) begin
        e_sstb = 1'b0; e_swe = 1'b0; e_saddr = '0; e_sdat = '0; e_gnt = 2'b00;
        o_stb  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_ack[k] = 1'b0; e_err[k] = 1'b0; e_dat[k] = '0;
        end
        if (!reset && mp_phase == 1) begin
            o_stb   = (mp_owner == 1) ? m1_STB : m0_STB;
            e_sstb  = o_stb;
            e_swe   = (mp_owner == 1) ? m1_WE : m0_WE;
            e_saddr = (mp_owner == 1) ? m1_ADDR : m0_ADDR;
            e_sdat  = (mp_owner == 1) ? m1_DAT_I : m0_DAT_I;
            e_gnt   = (mp_owner == 1) ? 2'b10 : 2'b01;
            e_ack[mp_owner] = s_ACK;
            e_err[mp_owner] = o_stb && !s_ACK && (mp_n == int'(TMO));
            e_dat[mp_owner] = s_DAT_I;
        end
        chk("s_STB",    32'(s_STB),  32'(e_sstb));
        chk("s_WE",     32'(s_WE),   32'(e_swe));
        chk("s_ADDR",   s_ADDR,      e_saddr);
        chk("s_DAT_O",  s_DAT_O,     e_sdat);
        chk("gnt",      32'(gnt),    32'(e_gnt));
        chk("m0_ACK",   32'(m0_ACK), 32'(e_ack[0]));
        chk("m1_ACK",   32'(m1_ACK), 32'(e_ack[1]));
        chk("m0_ERR",   32'(m0_ERR), 32'(e_err[0]));
        chk("m1_ERR",   32'(m1_ERR), 32'(e_err[1]));
        chk("m0_DAT_O", m0_DAT_O,    e_dat[0]);
        chk("m1_DAT_O", m1_DAT_O,    e_dat[1]);

        if (reset) begin
            mp_phase = 0; mp_last = 1; mp_n = 0;
        end else begin
            case (mp_phase)
                0: if (m0_STB || m1_STB) begin
                    mp_owner = (m0_STB && m1_STB) ? (1 - mp_last) : (m1_STB ? 1 : 0);
                    mp_phase = 1;
                    mp_n     = 1;
                end
                1: begin
                    if (s_ACK) begin
                        mp_last = mp_owner; mp_phase = 2;
                    end else if (!o_stb) begin
                        mp_last = mp_owner; mp_phase = 0;
                    end else if (mp_n == int'(TMO)) begin
                        mp_last = mp_owner; mp_phase = 2;
                    end else begin
                        mp_n++;
                    end
                end
                default: mp_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_STB = 0; m0_WE = 0; m0_ADDR = '0; m0_DAT_I = '0;
        m1_STB = 0; m1_WE = 0; m1_ADDR = '0; m1_DAT_I = '0;
        s_ACK = 0; s_DAT_I = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        look();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_s_STB", 32'(s_STB), 32'h0);
        tick();
        reset = 1'b0;

        // single read
        do_reset();
        m0_STB = 1; m0_WE = 0; m0_ADDR = 32'h100; m0_DAT_I = $urandom;
        tick(); look();
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_s_STB", 32'(s_STB), 32'h1);
        chk("rd_s_ADDR", s_ADDR, 32'h100);
        tick();
        tick();
        s_ACK = 1; s_DAT_I = 32'hDEADBEEF;
        look();
        chk("rd_ack", 32'(m0_ACK), 32'h1);
        chk("rd_data", m0_DAT_O, 32'hDEADBEEF);
        chk("rd_m1_data", m1_DAT_O, 32'h0);
        tick();
        m0_STB = 0; s_ACK = 0;
        look();
        chk("rd_release_gnt", 32'(gnt), 32'h0);
        chk("rd_release_ack", 32'(m0_ACK), 32'h0);
        tick(); look();
        chk("rd_idle_s_STB", 32'(s_STB), 32'h0);

        // contention with immediate ACK
        do_reset();
        m0_STB = 1; m1_STB = 1; s_ACK = 1;
        for (int i = 0; i < 12; i++) begin
            tick(); look();
            chk("rr_gnt", 32'(gnt), (i % 3 != 0) ? 32'h0 : (((i / 3) % 2 == 0) ? 32'h1 : 32'h2));
        end
        m0_STB = 0; m1_STB = 0; s_ACK = 0;
        tick();

        // timeout on an m1 write
        do_reset();
        m1_STB = 1; m1_WE = 1; m1_ADDR = $urandom; m1_DAT_I = $urandom;
        tick();
        repeat (253) tick();
        look();
        chk("to_err_early", 32'(m1_ERR), 32'h0);
        tick(); look();
        chk("to_err", 32'(m1_ERR), 32'h1);
        chk("to_ack", 32'(m1_ACK), 32'h0);
        chk("to_stb_held", 32'(s_STB), 32'h1);
        tick(); look();
        chk("to_stb_drop", 32'(s_STB), 32'h0);
        chk("to_err_gone", 32'(m1_ERR), 32'h0);
        m1_STB = 0;
        tick();

        // ACK and timeout in the same cycle
        do_reset();
        m0_STB = 1; m0_ADDR = $urandom;
        tick();
        repeat (254) tick();
        s_ACK = 1;
        look();
        chk("tie_ack", 32'(m0_ACK), 32'h1);
        chk("tie_err", 32'(m0_ERR), 32'h0);
        tick();
        m0_STB = 0; s_ACK = 0;
        look();
        chk("tie_release", 32'(gnt), 32'h0);
        tick();

        // abort by m0 while m1 pending
        do_reset();
        m0_STB = 1; m1_STB = 1;
        tick(); look();
        chk("ab_first", 32'(gnt), 32'h1);
        tick();
        tick();
        m0_STB = 0;
        look();
        chk("ab_s_STB", 32'(s_STB), 32'h0);
        chk("ab_no_ack", 32'(m0_ACK), 32'h0);
        tick(); look();
        chk("ab_idle", 32'(gnt), 32'h0);
        tick(); look();
        chk("ab_m1_gnt", 32'(gnt), 32'h2);
        s_ACK = 1;
        look();
        chk("ab_m1_ack", 32'(m1_ACK), 32'h1);
        tick();
        m1_STB = 0; s_ACK = 0;
        tick();

        // reset in the middle of a transfer
        do_reset();
        m1_STB = 1;
        tick();
        repeat (4) tick();
        reset = 1; s_ACK = 1;
        look();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_STB", 32'(s_STB), 32'h0);
        chk("rst_ack", 32'(m1_ACK), 32'h0);
        chk("rst_err", 32'(m1_ERR), 32'h0);
        tick();
        reset = 0; s_ACK = 0; m0_STB = 1;
        tick(); look();
        chk("rst_m0_first", 32'(gnt), 32'h1);
        m0_STB = 0; m1_STB = 0;
        tick();
        tick();

        // randomized traffic
        for (int cyc = 0; cyc < 20000; cyc++) begin
            tick();
            if (reset) reset = 0;
            else if ($urandom_range(0, 999) == 0) reset = 1;
            if (m0_STB) begin
                if ($urandom_range(0, 199) == 0) m0_STB = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                m0_STB = 1; m0_WE = 1'($urandom); m0_ADDR = $urandom; m0_DAT_I = $urandom;
            end
            if (m1_STB) begin
                if ($urandom_range(0, 199) == 0) m1_STB = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                m1_STB = 1; m1_WE = 1'($urandom); m1_ADDR = $urandom; m1_DAT_I = $urandom;
            end
            s_ACK   = ((cyc % 3000) < 700) ? 1'b0 : ($urandom_range(0, 2) == 0);
            s_DAT_I = $urandom;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
